// File: rtl/reg_native2apb_mst.sv
`default_nettype none
// ============================================================================
//  Module   : reg_native2apb_mst
//  Purpose  : Bridge from the reg_native_if responder side to an APB
//             initiator. Each accepted request is replayed as one APB
//             transfer (SETUP then ACCESS). A single-cycle ack_vld is then
//             returned together with rd_data and err.
//
//  Ports
//    fsm_clk               clock for the whole block
//    fsm_rst               asynchronous active-high reset
//    global_sync_reset_in  synchronous abort back to IDLE, no ack issued
//    req_vld/wr_en/rd_en   request strobe and direction (sampled in IDLE)
//    addr/wr_data          request address / write data
//    ack_vld               one-cycle completion pulse
//    rd_data/err           completion data / error, zero unless ack_vld
//    PSEL/PENABLE/PWRITE   APB control
//    PADDR/PWDATA          APB address / write data
//    PREADY/PRDATA/PSLVERR APB responder inputs
//
//  Revision : 1.0  initial release
// ============================================================================
module reg_native2apb_mst #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  fsm_clk,
    input  logic                  fsm_rst,
    input  logic                  global_sync_reset_in,
    // reg_native_if responder side
    input  logic                  req_vld,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ack_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err,
    // APB initiator side
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    // A disabled timeout still keeps a 1-bit counter so widths stay legal.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic               c_TMO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [c_CNT_W-1:0] c_TMO     = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;

    logic [1:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_psel_nxt;
    logic                  w_penable_nxt;
    logic                  w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0] w_paddr_nxt;
    logic [DATA_WIDTH-1:0] w_pwdata_nxt;
    logic                  w_ack_nxt;
    logic [DATA_WIDTH-1:0] w_rd_data_nxt;
    logic                  w_err_nxt;

    // Saturating increment: the wait counter never wraps.
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + c_CNT_ONE);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_pwrite_nxt  = PWRITE;
        w_paddr_nxt   = PADDR;
        w_pwdata_nxt  = PWDATA;
        w_ack_nxt     = 1'b0;
        w_rd_data_nxt = '0;
        w_err_nxt     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (req_vld) begin
                    if (wr_en ^ rd_en) begin
                        w_state_nxt  = c_ST_SETUP;
                        w_psel_nxt   = 1'b1;
                        w_paddr_nxt  = addr;
                        w_pwdata_nxt = wr_data;
                        w_pwrite_nxt = wr_en;
                        w_cnt_nxt    = '0;
                    end else begin
                        // Neither or both directions: reject locally,
                        // nothing goes out on APB.
                        w_ack_nxt = 1'b1;
                        w_err_nxt = 1'b1;
                    end
                end
            end

            c_ST_SETUP: begin
                w_state_nxt   = c_ST_ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end

            c_ST_ACCESS: begin
                if (PREADY) begin
                    // PREADY wins over a timeout reached in the same cycle.
                    w_state_nxt   = c_ST_IDLE;
                    w_ack_nxt     = 1'b1;
                    w_err_nxt     = PSLVERR;
                    w_rd_data_nxt = PWRITE ? '0 : PRDATA;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (c_TMO_EN && (w_cnt_inc == c_TMO)) begin
                        w_state_nxt = c_ST_IDLE;
                        w_ack_nxt   = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_psel_nxt    = 1'b1;
                        w_penable_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Synchronous abort overrides everything, including a pending
        // request or a PREADY in the same cycle, and suppresses the ack.
        if (global_sync_reset_in) begin
            w_state_nxt   = c_ST_IDLE;
            w_cnt_nxt     = '0;
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            w_pwrite_nxt  = 1'b0;
            w_paddr_nxt   = '0;
            w_pwdata_nxt  = '0;
            w_ack_nxt     = 1'b0;
            w_rd_data_nxt = '0;
            w_err_nxt     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers (all outputs are registered)
    // ------------------------------------------------------------------
    always_ff @(posedge fsm_clk or posedge fsm_rst) begin
        if (fsm_rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            ack_vld <= 1'b0;
            rd_data <= '0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            PSEL    <= w_psel_nxt;
            PENABLE <= w_penable_nxt;
            PWRITE  <= w_pwrite_nxt;
            PADDR   <= w_paddr_nxt;
            PWDATA  <= w_pwdata_nxt;
            ack_vld <= w_ack_nxt;
            rd_data <= w_rd_data_nxt;
            err     <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_native2apb_mst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_native2apb_mst
//  Purpose  : Self-checking bench for reg_native2apb_mst. Directed vector
//             table, hand-written abort/reset sequences and randomized
//             transactions scored against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_native2apb_mst;

    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int TMO = 4;

    // Request kinds
    localparam int K_WR    = 0;
    localparam int K_RD    = 1;
    localparam int K_ILL11 = 2;
    localparam int K_ILL00 = 3;

    logic          fsm_clk = 1'b0;
    logic          fsm_rst;
    logic          gsr;
    logic          req_vld;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          ack_vld;
    logic [DW-1:0] rd_data;
    logic          err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;

    int checks = 0;
    int errors = 0;

    reg_native2apb_mst #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .fsm_clk              (fsm_clk),
        .fsm_rst              (fsm_rst),
        .global_sync_reset_in (gsr),
        .req_vld              (req_vld),
        .wr_en                (wr_en),
        .rd_en                (rd_en),
        .addr                 (addr),
        .wr_data              (wr_data),
        .ack_vld              (ack_vld),
        .rd_data              (rd_data),
        .err                  (err),
        .PSEL                 (PSEL),
        .PENABLE              (PENABLE),
        .PWRITE               (PWRITE),
        .PADDR                (PADDR),
        .PWDATA               (PWDATA),
        .PREADY               (PREADY),
        .PRDATA               (PRDATA),
        .PSLVERR              (PSLVERR)
    );

    always #5 fsm_clk = ~fsm_clk;

    typedef struct {
        int          kind;
        logic [63:0] a;
        logic [31:0] d;
        int          waits;
        logic        se;
        logic [31:0] pr;
        int          lat;   // cycles from request edge to ack cycle
        logic        e;
        logic [31:0] rd;
        int          pc;    // cycles with PSEL high
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation from the bridge rules: illegal requests
    // ack next cycle; otherwise SETUP + (waits+1) ACCESS cycles unless that
    // exceeds the timeout budget of TMO ACCESS cycles.
    function automatic void model(input int kind, input int waits, input logic se,
                                  input logic [31:0] pr, output int lat, output logic e,
                                  output logic [31:0] rd, output int pc);
        if (kind == K_ILL11 || kind == K_ILL00) begin
            lat = 1; e = 1'b1; rd = '0; pc = 0;
        end else if (waits + 1 > TMO) begin
            lat = 2 + TMO; e = 1'b1; rd = '0; pc = 1 + TMO;
        end else begin
            lat = 3 + waits; e = se; rd = (kind == K_RD) ? pr : '0; pc = 2 + waits;
        end
    endfunction

    task automatic idle(input int n);
        req_vld = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge fsm_clk); #1;
            check("idle_quiet", 64'({ack_vld, PSEL, PENABLE, err, (rd_data != '0)}), 64'd0);
            PREADY  = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
        end
    endtask

    // Issue one request (in the current cycle) and play a responder that
    // raises PREADY on ACCESS cycle waits+1.
    task automatic do_txn(input string name, input int kind, input logic [63:0] a,
                          input logic [31:0] d, input int waits, input logic se,
                          input logic [31:0] pr, input int exp_lat, input logic exp_e,
                          input logic [31:0] exp_rd, input int exp_pc);
        int          cyc = 0;
        int          pc = 0;
        int          acc = 0;
        logic        got = 1'b0;
        logic        stable = 1'b1;
        logic        quiet = 1'b1;
        logic        psel_ack = 1'b0;
        logic [31:0] rdv = '0;
        logic        ev = 1'b0;

        req_vld = 1'b1;
        wr_en   = (kind == K_WR) || (kind == K_ILL11);
        rd_en   = (kind == K_RD) || (kind == K_ILL11);
        addr    = a;
        wr_data = d;
        while (!got && cyc < 30) begin
            @(posedge fsm_clk); #1;
            cyc++;
            req_vld = 1'b0;
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            addr    = {$urandom, $urandom};
            wr_data = $urandom;
            if (PSEL) begin
                pc++;
                if (PADDR !== a || PWDATA !== d || PWRITE !== (kind == K_WR)) stable = 1'b0;
            end
            if (ack_vld) begin
                got = 1'b1; rdv = rd_data; ev = err; psel_ack = PSEL;
            end else if (rd_data !== '0 || err !== 1'b0) begin
                quiet = 1'b0;
            end
            if (PSEL && PENABLE) begin
                if (acc == waits) begin
                    PREADY = 1'b1; PRDATA = pr; PSLVERR = se;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
                end
                acc++;
            end else begin
                PREADY  = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end
        check({name, ".latency"}, got ? 64'(cyc) : 64'hFFFF_FFFF, 64'(exp_lat));
        check({name, ".err"},     64'(ev),       64'(exp_e));
        check({name, ".rd_data"}, 64'(rdv),      64'(exp_rd));
        check({name, ".psel_cycles"}, 64'(pc),   64'(exp_pc));
        check({name, ".apb_stable"},  64'(stable), 64'd1);
        check({name, ".zero_no_ack"}, 64'(quiet),  64'd1);
        check({name, ".psel_in_ack"}, 64'(psel_ack), 64'd0);
    endtask

    // Wait until the DUT shows an ACCESS cycle, responder held not-ready.
    task automatic reach_access(input string name);
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge fsm_clk); #1;
            n++;
            req_vld = 1'b0;
            PREADY  = 1'b0;
            if (PSEL && PENABLE) seen = 1'b1;
        end
        check({name, ".reach_access"}, 64'(seen), 64'd1);
    endtask

    vec_t        tbl[9];
    int          kind, w, lat, pc, g, r;
    logic        se, e;
    logic [63:0] a;
    logic [31:0] d, pr, rd;

    initial begin
        //            kind    addr   wdata         waits se pr            lat e  rd            pc
        tbl[0] = '{K_WR,    64'h10, 32'h1111_1111, 0, 1'b0, 32'h9999_0000, 3, 1'b0, 32'h0,         2};
        tbl[1] = '{K_RD,    64'h18, 32'h0BAD_0BAD, 3, 1'b0, 32'hAAAA_AAAA, 6, 1'b0, 32'hAAAA_AAAA, 5};
        tbl[2] = '{K_RD,    64'h20, 32'h0,         1, 1'b1, 32'h1234_5678, 4, 1'b1, 32'h1234_5678, 3};
        tbl[3] = '{K_RD,    64'h28, 32'h0,         9, 1'b0, 32'h5555_5555, 6, 1'b1, 32'h0,         5};
        tbl[4] = '{K_WR,    64'h30, 32'hDEAD_BEEF, 2, 1'b0, 32'h7777_7777, 5, 1'b0, 32'h0,         4};
        tbl[5] = '{K_ILL11, 64'h34, 32'h1,         0, 1'b0, 32'h1,         1, 1'b1, 32'h0,         0};
        tbl[6] = '{K_ILL00, 64'h38, 32'h2,         0, 1'b0, 32'h2,         1, 1'b1, 32'h0,         0};
        tbl[7] = '{K_WR,    64'h3C, 32'hFEED_F00D, 0, 1'b1, 32'h3,         3, 1'b1, 32'h0,         2};
        tbl[8] = '{K_RD,    64'hFFFF_FFFF_FFFF_FFF0, 32'h4, 4, 1'b0, 32'h5A5A_5A5A, 6, 1'b1, 32'h0, 5};

        fsm_rst = 1'b1; gsr = 1'b0; req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; wr_data = '0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;

        repeat (3) @(posedge fsm_clk);
        #1;
        check("reset_ctrl",   64'({PSEL, PENABLE, PWRITE, ack_vld, err}), 64'd0);
        check("reset_paddr",  PADDR, 64'd0);
        check("reset_pwdata", 64'(PWDATA), 64'd0);
        check("reset_rddata", 64'(rd_data), 64'd0);
        fsm_rst = 1'b0;
        idle(2);

        // Directed table, issued back-to-back in each ack cycle.
        for (int i = 0; i < 9; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].kind, tbl[i].a, tbl[i].d, tbl[i].waits,
                   tbl[i].se, tbl[i].pr, tbl[i].lat, tbl[i].e, tbl[i].rd, tbl[i].pc);
        end
        idle(1);

        // Synchronous abort during ACCESS, with PREADY in the same cycle.
        req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = 64'h40; wr_data = 32'h1234;
        reach_access("abort");
        gsr = 1'b1; PREADY = 1'b1; PRDATA = 32'hCAFE; PSLVERR = 1'b0;
        @(posedge fsm_clk); #1;
        gsr = 1'b0; PREADY = 1'b0;
        check("abort_psel_penable", 64'({PSEL, PENABLE}), 64'd0);
        check("abort_no_ack",       64'(ack_vld), 64'd0);
        check("abort_paddr",        PADDR, 64'd0);
        check("abort_pwrite_pwdata", 64'({PWRITE, PWDATA}), 64'd0);
        check("abort_err_rd",       64'({err, rd_data}), 64'd0);
        idle(3);
        do_txn("post_abort_wr", K_WR, 64'h10, 32'h2222_2222, 1, 1'b0, 32'h0, 4, 1'b0, 32'h0, 3);

        // Synchronous abort overriding a simultaneous request in IDLE.
        req_vld = 1'b1; wr_en = 1'b1; rd_en = 1'b0; addr = 64'h50; wr_data = 32'h5050;
        gsr = 1'b1;
        @(posedge fsm_clk); #1;
        gsr = 1'b0; req_vld = 1'b0;
        check("gsr_over_req_psel", 64'({PSEL, ack_vld}), 64'd0);
        idle(3);

        // Asynchronous reset in the middle of ACCESS.
        req_vld = 1'b1; wr_en = 1'b1; rd_en = 1'b0; addr = 64'h60; wr_data = 32'h7777;
        reach_access("arst");
        #2 fsm_rst = 1'b1;
        #1;
        check("arst_psel_immediate", 64'({PSEL, PENABLE, ack_vld}), 64'd0);
        #3 fsm_rst = 1'b0;
        idle(2);
        do_txn("post_arst_wr", K_WR, 64'h68, 32'h6868_6868, 0, 1'b0, 32'h0, 3, 1'b0, 32'h0, 2);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            r    = $urandom_range(0, 9);
            kind = (r < 4) ? K_WR : (r < 8) ? K_RD : (r == 8) ? K_ILL11 : K_ILL00;
            a    = {$urandom, $urandom};
            d    = $urandom;
            w    = $urandom_range(0, 6);
            se   = 1'($urandom_range(0, 1));
            pr   = $urandom;
            model(kind, w, se, pr, lat, e, rd, pc);
            do_txn($sformatf("rnd%0d", i), kind, a, d, w, se, pr, lat, e, rd, pc);
            g = $urandom_range(0, 2);
            if (g != 0) idle(g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
